// File: rtl/input_loader_if.sv
// Sample-stream handshake bundle for the FFT input loader.
// master = upstream source, slave = loader; carries re/im, valid, ready.
interface input_loader_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_re, in_im, in_valid,
    input  in_ready
  );

  modport slave (
    input  in_re, in_im, in_valid,
    output in_ready
  );
endinterface

// File: rtl/input_loader.sv
// Input-side frame collector: buffers one N-point frame, pulses dataind, holds it until core_done.
// Ports: clk, rst (async high), smp (sample handshake), rd_addr/rd_re/rd_im (registered read port), dataind, core_done, counter_o, busy.
module input_loader #(
  parameter int DATA_W = 16,
  parameter int N_LOG2 = 6,
  parameter bit BITREV = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input_loader_if.slave     smp,
  input  logic [N_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_re,
  output logic [DATA_W-1:0] rd_im,
  output logic              dataind,
  input  logic              core_done,
  output logic [N_LOG2-1:0] counter_o,
  output logic              busy
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int DEPTH = 1 << N_LOG2;

  logic [1:0]          state_q, state_d;
  logic [N_LOG2-1:0]   cnt_q, cnt_d;
  logic [N_LOG2-1:0]   cnt_o_q;
  logic                dataind_q, dataind_d;
  logic [DATA_W-1:0]   rd_re_q, rd_im_q;
  logic [N_LOG2-1:0]   wr_addr;
  logic                accept;
  logic                st_fill, st_start, st_hold;

  logic [2*DATA_W-1:0] mem_q [DEPTH];

  function automatic logic [N_LOG2-1:0] rev(
    input logic [N_LOG2-1:0] a
  );
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++)
      r[i] = a[N_LOG2-1-i];
    return r;
  endfunction

  assign st_fill  = (state_q == FILL);
  assign st_start = (state_q == START);
  assign st_hold  = (state_q == HOLD);

  // ready/busy come from the state register only
  assign smp.in_ready = st_fill;
  assign busy         = st_start | st_hold;
  assign accept       = st_fill & smp.in_valid;
  assign wr_addr      = BITREV ? rev(cnt_q) : cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dataind_d = 1'b0;
    unique case (1'b1)
      st_fill: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d   = START;
            dataind_d = 1'b1;
          end
        end
      end
      st_start: state_d = HOLD;
      st_hold: begin
        if (core_done)
          state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      cnt_o_q   <= '0;
      dataind_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cnt_o_q   <= cnt_d;
      dataind_q <= dataind_d;
    end
  end

  // frame buffer is deliberately not reset
  always_ff @(posedge clk) begin
    if (accept)
      mem_q[wr_addr] <= {smp.in_re, smp.in_im};
  end

  // read-before-write: same-address write returns old data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_re_q <= '0;
      rd_im_q <= '0;
    end else begin
      {rd_re_q, rd_im_q} <= mem_q[rd_addr];
    end
  end

  assign rd_re     = rd_re_q;
  assign rd_im     = rd_im_q;
  assign dataind   = dataind_q;
  assign counter_o = cnt_o_q;

endmodule

// File: tb/tb_input_loader.sv
// Testbench for input_loader: two instances (bit-reversed and natural order)
// driven identically and checked against a sample-indexed frame model.
module tb_input_loader;
  localparam int DW = 16;
  localparam int NL = 6;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_loader_if #(.DATA_W(DW)) s1 ();
  input_loader_if #(.DATA_W(DW)) s0 ();

  logic [NL-1:0] rd_addr;
  logic          core_done;
  logic [DW-1:0] re1, im1, re0, im0;
  logic          di1, di0, b1, b0;
  logic [NL-1:0] c1, c0;

  input_loader #(.DATA_W(DW), .N_LOG2(NL), .BITREV(1'b1)) u1 (
    .clk(clk), .rst(rst), .smp(s1), .rd_addr(rd_addr),
    .rd_re(re1), .rd_im(im1), .dataind(di1),
    .core_done(core_done), .counter_o(c1), .busy(b1)
  );

  input_loader #(.DATA_W(DW), .N_LOG2(NL), .BITREV(1'b0)) u0 (
    .clk(clk), .rst(rst), .smp(s0), .rd_addr(rd_addr),
    .rd_re(re0), .rd_im(im0), .dataind(di0),
    .core_done(core_done), .counter_o(c0), .busy(b0)
  );

  typedef struct {
    int            addr;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } vec_t;

  vec_t tbl [6];

  int cmp = 0;
  int bad = 0;

  // model: frame as sample index -> value, plus ownership
  int            n;
  bit            owned;
  int            since;
  logic [DW-1:0] sre [N];
  logic [DW-1:0] sim [N];
  bit            wr  [N];
  logic [DW-1:0] e_re1, e_im1, e_re0, e_im0;
  bit            e_v1, e_v0;

  function automatic int rev(input int a);
    int r;
    r = 0;
    for (int i = 0; i < NL; i++)
      if (a[i]) r = r | (1 << (NL - 1 - i));
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ready1", 32'(s1.in_ready), 32'(!owned));
    chk("ready0", 32'(s0.in_ready), 32'(!owned));
    chk("dataind1", 32'(di1), 32'(owned && since == 0));
    chk("dataind0", 32'(di0), 32'(owned && since == 0));
    chk("busy1", 32'(b1), 32'(owned));
    chk("busy0", 32'(b0), 32'(owned));
    chk("count1", 32'(c1), 32'(n));
    chk("count0", 32'(c0), 32'(n));
    if (e_v1) begin
      chk("rd_re1", 32'(re1), 32'(e_re1));
      chk("rd_im1", 32'(im1), 32'(e_im1));
    end
    if (e_v0) begin
      chk("rd_re0", 32'(re0), 32'(e_re0));
      chk("rd_im0", 32'(im0), 32'(e_im0));
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] re,
                       input logic [DW-1:0] im, input bit done,
                       input int addr);
    s1.in_valid = v;  s0.in_valid = v;
    s1.in_re    = re; s0.in_re    = re;
    s1.in_im    = im; s0.in_im    = im;
    core_done   = done;
    rd_addr     = NL'(addr);
  endtask

  // one clock: drive, update model, check after the edge
  task automatic cyc(input bit v, input logic [DW-1:0] re,
                     input logic [DW-1:0] im, input bit done,
                     input int addr);
    int ra;
    drive(v, re, im, done, addr);
    ra    = rev(addr);
    e_re1 = sre[ra];   e_im1 = sim[ra];   e_v1 = wr[ra];
    e_re0 = sre[addr]; e_im0 = sim[addr]; e_v0 = wr[addr];
    if (!owned) begin
      if (v) begin
        sre[n] = re;
        sim[n] = im;
        wr[n]  = 1'b1;
        n = (n + 1) % N;
        if (n == 0) begin
          owned = 1'b1;
          since = 0;
        end
      end
    end else if (since >= 1 && done) begin
      owned = 1'b0;
    end else begin
      since++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    owned = 1'b0;
    n     = 0;
    since = 0;
    e_re1 = '0; e_im1 = '0; e_v1 = 1'b1;
    e_re0 = '0; e_im0 = '0; e_v0 = 1'b1;
  endtask

  // asynchronous pulse between clock edges
  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int first;

    tbl[0] = '{addr: 32, re: 16'd1,  im: 16'hFFFF};
    tbl[1] = '{addr: 24, re: 16'd6,  im: 16'hFFFA};
    tbl[2] = '{addr: 0,  re: 16'd0,  im: 16'h0000};
    tbl[3] = '{addr: 63, re: 16'd63, im: 16'hFFC1};
    tbl[4] = '{addr: 1,  re: 16'd32, im: 16'hFFE0};
    tbl[5] = '{addr: 16, re: 16'd2,  im: 16'hFFFE};

    for (int i = 0; i < N; i++) wr[i] = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // ramp frame: re=k, im=-k
    first = -1;
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, DW'(k), DW'(-k), 1'b0, 0);
      if (di1 && first < 0) first = k;
    end
    chk("ramp_first_dataind", 32'(first), 32'd63);

    // core_done during START is ignored
    cyc(1'b0, '0, '0, 1'b1, 0);
    chk("start_done_busy", 32'(b1), 32'd1);

    // bit-reversed reads while upstream keeps pushing
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, DW'($urandom), DW'($urandom), 1'b0, tbl[i].addr);
      chk("tbl_re", 32'(re1), 32'(tbl[i].re));
      chk("tbl_im", 32'(im1), 32'(tbl[i].im));
    end
    for (int a = 0; a < N; a++) begin
      cyc(1'b1, DW'($urandom), DW'($urandom), 1'b0, a);
      chk("nat_re", 32'(re0), 32'(a));
    end
    cyc(1'b1, DW'($urandom), DW'($urandom), 1'b1, 0);
    chk("release_ready", 32'(s1.in_ready), 32'd1);

    // gapped input with stray core_done in FILL
    first = -1;
    for (int i = 0; i < 140; i++) begin
      cyc(i % 2 == 0, DW'($urandom), DW'($urandom),
          (i < 120) && (i % 7 == 3), $urandom_range(N - 1));
      if (di1 && first < 0) first = i;
    end
    chk("gap_first_dataind", 32'(first), 32'd126);
    cyc(1'b0, '0, '0, 1'b1, 0);

    // reset after 40 accepts
    for (int k = 0; k < 40; k++)
      cyc(1'b1, DW'($urandom), DW'($urandom), 1'b0, k);
    do_reset();
    first = -1;
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, DW'(k + 100), DW'($urandom), 1'b0, k);
      if (di1 && first < 0) first = k;
    end
    chk("rst_first_dataind", 32'(first), 32'd63);

    // reset while dataind is high
    do_reset();
    chk("rst_start_dataind", 32'(di1), 32'd0);

    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(3) != 0, DW'($urandom), DW'($urandom),
          $urandom_range(15) == 0, $urandom_range(N - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, bad);
    $finish;
  end

endmodule

// File: doc/input_loader.md
Name: input_loader

Overview:
- Input-side frame collector for the 64-point FFT processor. It is the counterpart of the output-side counter, which consumes dataind.
- Accepts a stream of complex samples through a valid/ready handshake and stores one 64-sample frame in an internal buffer, optionally at bit-reversed addresses.
- When the frame is complete, it issues a one-cycle dataind pulse to the FFT core.
- It then holds the frame, readable by the core, until the core signals completion.

Parameters:
DATA_W, 16, width of each real/imag component (two's complement)
N_LOG2, 6, log2 of frame length (64 points); counters and addresses are N_LOG2 bits
BITREV, 1, 1 = store sample k at bit-reversed address of k; 0 = natural order

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_re  input  DATA_W  input sample, real part
in_im  input  DATA_W  input sample, imaginary part
in_valid  input  1  upstream sample valid
in_ready  output  1  loader can accept a sample this cycle
rd_addr  input  N_LOG2  core read address into frame buffer
rd_re  output  DATA_W  buffer read data, real, registered
rd_im  output  DATA_W  buffer read data, imag, registered
dataind  output  1  one-cycle pulse: frame complete, core may start
core_done  input  1  one-cycle pulse from core: frame consumed, buffer released
counter_o  output  N_LOG2  samples accepted so far in current frame
busy  output  1  high while a frame is owned by the core (START or HOLD)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=FILL, counter=0, counter_o=0, dataind=0, busy=0, rd_re=0, rd_im=0. Buffer contents are not reset (undefined until written).
- States: FILL, START, HOLD. State is held in a register; in_ready and busy are decoded from that register only, with no combinational path from in_valid.
- FILL:
  - in_ready=1.
  - Accept = in_valid & in_ready. On accept, write {in_re,in_im} to addr = BITREV ? bitrev(counter) : counter, then counter <= counter+1.
  - On accept with counter==63: counter wraps to 0 and next state is START.
  - No accept: counter holds.
  - core_done is ignored in FILL.
- START:
  - Lasts exactly one cycle; dataind=1 this cycle only (registered, asserted the cycle after the 64th accept).
  - in_ready=0, busy=1. Always goes to HOLD next.
  - core_done in START is ignored.
- HOLD:
  - in_ready=0, busy=1, dataind=0.
  - On core_done=1: next state is FILL, and in_ready=1 from the following cycle.
  - Samples presented in HOLD are not accepted and are not lost upstream, because ready stays low.
- counter_o mirrors counter (registered copy, same cycle as counter).
- Read port: rd_re/rd_im <= buffer[rd_addr] on every clk, in any state; one-cycle latency.
  - Same-cycle write and read of the same address returns the old data. This can only occur in FILL; the core must not read during FILL.
- Bit reversal: reverse all N_LOG2 bits. For example, k=1 (000001) goes to address 32 (100000), and k=6 (000110) goes to address 24 (011000).
- Reset mid-frame: the partial frame is abandoned, counter returns to 0, and the next accepted sample is sample 0 of a new frame.
- Reset during START: dataind drops immediately (asynchronous reset).
- Throughput: minimum 64 accept cycles + 1 START cycle + core hold time per frame. Back-to-back frames are separated by at least the core_done latency.

Test Plan:
- Reset then 64 consecutive in_valid with in_re=k, in_im=-k, BITREV=1 -> dataind high exactly one cycle, the cycle after the 64th accept; busy=1; then reading rd_addr=32 returns re=1, im=-1 one cycle later, and rd_addr=24 returns re=6.
- Same stimulus with BITREV=0 -> rd_addr=a returns re=a for all 64 addresses; counter_o counts 0..63 then 0.
- In HOLD, drive in_valid=1 for 10 cycles then pulse core_done -> in_ready=0 throughout HOLD, no write occurs (buffer unchanged), and in_ready=1 on the cycle after core_done.
- Gapped input (in_valid toggling 1,0,1,0) -> counter advances only on accepts; dataind fires after the 64th accept (128 cycles); core_done pulsed during FILL has no effect.
- Assert rst asynchronously after 40 accepts, release, then send 64 samples -> no dataind before the new 64th accept; counter_o restarts at 0.
- core_done pulsed in the START cycle -> ignored; the loader stays in HOLD until a later core_done.
